// File: rtl/serial_arithmetic_unit.sv
// rtl/serial_arithmetic_unit.sv - word-serial add/sub/inc/dec unit; optional zero/overflow flags under ARITH_STATUS_FLAGS_EN
module serial_arithmetic_unit #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               carry_in,
    input  logic [1:0]         select,
    output logic               busy,
    output logic               done,
    output logic               carry_out,
    output logic [N*WORDS-1:0] result
`ifdef ARITH_STATUS_FLAGS_EN
    ,
    output logic               zero,
    output logic               overflow
`endif
);

    localparam int W     = N * WORDS;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] word_cnt;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [W-1:0]     acc;
    logic             carry_q;

    logic             accept;
    logic             last_word;
    logic [W-1:0]     eff_b;
    logic             init_carry;
    logic [N:0]       word_sum;
    logic [W-1:0]     acc_next;

    // Start is honoured only when no operation is in flight
    always_comb begin
        accept    = start && ((state == S_IDLE) || (state == S_DONE));
        last_word = (word_cnt == LAST_WORD);
    end

    // Operand B modifier and carry seed derived from the operation code
    always_comb begin
        eff_b = b;
        case (select)
            2'b00:   eff_b = b;
            2'b01:   eff_b = ~b;
            2'b10:   eff_b = '0;
            default: eff_b = '1;
        endcase
        init_carry = (select[0] == select[1]) ? carry_in : 1'b1;
    end

    // One N-bit slice per cycle; the new word enters the accumulator from the top
    always_comb begin
        word_sum = {1'b0, op_a[N-1:0]} + {1'b0, op_b[N-1:0]} + {{N{1'b0}}, carry_q};
        acc_next = (acc >> N) | (W'(word_sum[N-1:0]) << (W - N));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = start ? S_RUN : S_IDLE;
            S_RUN:   state_next = last_word ? S_DONE : S_RUN;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // Operand capture, serial datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            carry_q   <= 1'b0;
            word_cnt  <= '0;
            result    <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            op_a     <= a;
            op_b     <= eff_b;
            carry_q  <= init_carry;
            word_cnt <= '0;
        end else if (state == S_RUN) begin
            op_a     <= op_a >> N;
            op_b     <= op_b >> N;
            acc      <= acc_next;
            carry_q  <= word_sum[N];
            word_cnt <= word_cnt + 1'b1;
            if (last_word) begin
                result    <= acc_next;
                carry_out <= word_sum[N];
            end
        end
    end

`ifdef ARITH_STATUS_FLAGS_EN
    logic overflow_next;

    // Signed overflow: like-signed inputs producing an opposite-signed top bit
    always_comb begin
        overflow_next = (op_a[N-1] == op_b[N-1]) && (word_sum[N-1] != op_a[N-1]);
    end

    // Flags follow the result register, refreshed on the final word only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else if (!accept && (state == S_RUN) && last_word) begin
            zero     <= (acc_next == '0);
            overflow <= overflow_next;
        end
    end
`endif

endmodule
